shift_sequencer: RTL and testbench

Multi-cycle shift controller for the execute stage. Accepts a 32-bit operand, a 5-bit shift amount and an opcode (SRA or SLL), then iterates a single fixed-distance shift stage (arithmetic right-by-1 / logical left-by-1) over successive cycles until the requested distance is reached. Presents the result with a one-cycle ready pulse. Supports pipeline flush and start/busy handshaking so the stall logic can hold dependent instructions.

---
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates an SRA/SLL shift stage until the requested distance is consumed.
// Optional SHIFT_MULTI_STAGE_EN: each step shifts by the largest of 16/8/4/2/1 not exceeding the remaining distance.
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic        ctrl_flush,
  input  logic        op_sll,
  input  logic [31:0] data_operand,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic signed [31:0] work_q;
  logic signed [31:0] work_d;
  logic [4:0]         rem_q;
  logic [4:0]         rem_d;
  logic [4:0]         step;
  logic               sll_q;
  logic [31:0]        result_q;
  logic               rdy_q;
  logic               busy_q;

  // Arithmetic right fills with the sign bit; left shift always zero-fills.
  function automatic logic signed [31:0] shift_step(input logic signed [31:0] v,
                                                    input logic sll,
                                                    input logic [4:0] n);
    return sll ? (v <<< n) : (v >>> n);
  endfunction

`ifdef SHIFT_MULTI_STAGE_EN
  function automatic logic [4:0] step_size(input logic [4:0] rem);
    if (rem[4])      return 5'd16;
    else if (rem[3]) return 5'd8;
    else if (rem[2]) return 5'd4;
    else if (rem[1]) return 5'd2;
    else             return 5'd1;
  endfunction
`endif

  always_comb begin
`ifdef SHIFT_MULTI_STAGE_EN
    step = step_size(rem_q);
`else
    step = 5'd1;
`endif
    work_d = shift_step(work_q, sll_q, step);
    rem_d  = rem_q - step;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      sll_q    <= 1'b0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ctrl_flush) begin
      // Abandoned operation: no RDY pulse, last completed result stays visible.
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          rdy_q  <= 1'b0;
          busy_q <= 1'b0;
          if (ctrl_shift) begin
            work_q <= data_operand;
            rem_q  <= shamt;
            sll_q  <= op_sll;
            if (shamt == 5'd0) begin
              state_q  <= DONE;
              rdy_q    <= 1'b1;
              result_q <= data_operand;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == 5'd0) begin
            state_q  <= DONE;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= work_d;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized operations against a reference model.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_shift = 1'b0;
  logic        ctrl_flush = 1'b0;
  logic        op_sll = 1'b0;
  logic [31:0] data_operand = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res;

  shift_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_shift(ctrl_shift), .ctrl_flush(ctrl_flush),
    .op_sll(op_sll), .data_operand(data_operand), .shamt(shamt),
    .data_result(data_result), .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic sll, input logic [4:0] n);
    logic signed [31:0] s;
    s = v;
    if (sll) return v << n;
    return 32'(s >>> n);
  endfunction

  function automatic int ref_steps(input logic [4:0] n);
`ifdef SHIFT_MULTI_STAGE_EN
    return $countones(n);
`else
    return int'(n);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [31:0] v, input logic sll, input logic [4:0] n);
    data_operand = v;
    op_sll       = sll;
    shamt        = n;
    ctrl_shift   = 1'b1;
  endtask

  // Called while a start request is pending; returns #1 after the edge that raises RDY.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int k, input bit noise);
    int cycles;
    @(posedge clock); #1;
    ctrl_shift = 1'b0;
    cycles = 0;
    while (!data_resultRDY && cycles < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (noise) begin
        ctrl_shift   = 1'($urandom_range(0, 1));
        data_operand = $urandom;
        shamt        = 5'($urandom);
        op_sll       = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
      ctrl_shift = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(k));
    check({tag, "_result"}, data_result, exp);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (data_resultRDY) last_res = data_result;
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  n;
    logic        s;

    #12;
    check("reset_result", data_result, 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clock); reset = 1'b0;
    last_res = '0;

    // SRA sign fill
    @(negedge clock); drive_op(32'h8000_0000, 1'b0, 5'd4);
    finish_op("sra4", 32'hF800_0000, ref_steps(5'd4), 1'b0);
    @(posedge clock); #1;
    check("rdy_one_cycle", 32'(data_resultRDY), 32'd0);
    check("idle_hold", data_result, 32'hF800_0000);

    // SLL full distance with ignored start pulses during SHIFT
    @(negedge clock); drive_op(32'h0000_0001, 1'b1, 5'd31);
    finish_op("sll31", 32'h8000_0000, ref_steps(5'd31), 1'b1);

    @(negedge clock); drive_op(32'h8000_0000, 1'b0, 5'd31);
    finish_op("sra31", 32'hFFFF_FFFF, ref_steps(5'd31), 1'b0);

    // Zero distance
    @(negedge clock); drive_op(32'h1234_5678, 1'b0, 5'd0);
    finish_op("sh0", 32'h1234_5678, 0, 1'b0);

    // Back-to-back: second start issued in the first DONE cycle
    @(negedge clock); drive_op(32'hFFFF_0000, 1'b0, 5'd8);
    finish_op("b2b_a", 32'hFFFF_FF00, ref_steps(5'd8), 1'b0);
    drive_op(32'h0000_000F, 1'b1, 5'd4);
    finish_op("b2b_b", 32'h0000_00F0, ref_steps(5'd4), 1'b0);

    // Flush mid-SHIFT, with a simultaneous start that must lose
    @(negedge clock); drive_op(32'h7FFF_FFFF, 1'b0, 5'd20);
    @(posedge clock); #1; ctrl_shift = 1'b0;
    @(posedge clock); #1;
    ctrl_flush = 1'b1; ctrl_shift = 1'b1;
    @(posedge clock); #1;
    ctrl_flush = 1'b0; ctrl_shift = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rdy", 32'(data_resultRDY), 32'd0);
    check("flush_hold", data_result, 32'h0000_00F0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      check("flush_no_rdy", 32'(data_resultRDY), 32'd0);
    end
    @(negedge clock); drive_op(32'h7FFF_FFFF, 1'b0, 5'd20);
    finish_op("post_flush", 32'h0000_07FF, ref_steps(5'd20), 1'b0);

    // Asynchronous reset mid-SHIFT
    @(negedge clock); drive_op(32'hA5A5_A5A5, 1'b1, 5'd31);
    @(posedge clock); #1; ctrl_shift = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("areset_result", data_result, 32'd0);
    check("areset_rdy", 32'(data_resultRDY), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); drive_op(32'h0000_00F0, 1'b0, 5'd4);
    finish_op("post_reset", 32'h0000_000F, ref_steps(5'd4), 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      v = $urandom;
      n = 5'($urandom);
      s = 1'($urandom_range(0, 1));
      @(negedge clock); drive_op(v, s, n);
      finish_op($sformatf("rand%0d", i), ref_shift(v, s, n), ref_steps(n), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
